// File: rtl/reloj_bcd_24h.sv
// 24-hour BCD time-of-day counter (HH:MM) with a 1 s prescaler, hidden seconds,
// a set mode that advances hours/minutes from button pulses, and a colon blink output.
module reloj_bcd_24h #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SetMode,
    input  logic       IncHor,
    input  logic       IncMin,
    output logic [3:0] DecHor,
    output logic [3:0] UniHor,
    output logic [3:0] DecMin,
    output logic [3:0] UniMin,
    output logic       SecBlink
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [5:0]    sec_q, sec_d;
    logic [3:0]    dec_hor_q, dec_hor_d, uni_hor_q, uni_hor_d;
    logic [3:0]    dec_min_q, dec_min_d, uni_min_q, uni_min_d;
    logic          blink_q, blink_d;
    logic          tick, min_step, hor_step;

    // Tick is suppressed while setting, so a SetMode rise on terminal count never advances time.
    assign tick = (prescaler_q == PS_LAST) && !SetMode;

    always_comb begin
        prescaler_d = prescaler_q;
        sec_d       = sec_q;
        blink_d     = blink_q;
        dec_hor_d   = dec_hor_q;
        uni_hor_d   = uni_hor_q;
        dec_min_d   = dec_min_q;
        uni_min_d   = uni_min_q;
        min_step    = 1'b0;
        hor_step    = 1'b0;

        if (SetMode) begin
            prescaler_d = '0;
            sec_d       = '0;
            blink_d     = 1'b0;
            min_step    = IncMin;
            hor_step    = IncHor;
        end else begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
            if (tick) begin
                blink_d = ~blink_q;
                if (sec_q == 6'd59) begin
                    sec_d    = '0;
                    min_step = 1'b1;
                    hor_step = (dec_min_q == 4'd5) && (uni_min_q == 4'd9);
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end

        if (min_step) begin
            if (uni_min_q == 4'd9) begin
                uni_min_d = 4'd0;
                dec_min_d = (dec_min_q == 4'd5) ? 4'd0 : dec_min_q + 4'd1;
            end else begin
                uni_min_d = uni_min_q + 4'd1;
            end
        end

        if (hor_step) begin
            if ((dec_hor_q == 4'd2) && (uni_hor_q == 4'd3)) begin
                dec_hor_d = 4'd0;
                uni_hor_d = 4'd0;
            end else if (uni_hor_q == 4'd9) begin
                uni_hor_d = 4'd0;
                dec_hor_d = dec_hor_q + 4'd1;
            end else begin
                uni_hor_d = uni_hor_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            sec_q       <= '0;
            blink_q     <= 1'b0;
            dec_hor_q   <= '0;
            uni_hor_q   <= '0;
            dec_min_q   <= '0;
            uni_min_q   <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            sec_q       <= sec_d;
            blink_q     <= blink_d;
            dec_hor_q   <= dec_hor_d;
            uni_hor_q   <= uni_hor_d;
            dec_min_q   <= dec_min_d;
            uni_min_q   <= uni_min_d;
        end
    end

    assign DecHor   = dec_hor_q;
    assign UniHor   = uni_hor_q;
    assign DecMin   = dec_min_q;
    assign UniMin   = uni_min_q;
    assign SecBlink = blink_q;
endmodule

// File: tb/tb_reloj_bcd_24h.sv
// Bench for reloj_bcd_24h: time-of-day model in plain seconds arithmetic checked every cycle,
// plus hand-computed directed expectations.
module tb_reloj_bcd_24h;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst, SetMode, IncHor, IncMin;
    logic [3:0] DecHor, UniHor, DecMin, UniMin;
    logic       SecBlink;

    int vectors = 0;
    int miscompares = 0;

    reloj_bcd_24h #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst(rst), .SetMode(SetMode), .IncHor(IncHor), .IncMin(IncMin),
        .DecHor(DecHor), .UniHor(UniHor), .DecMin(DecMin), .UniMin(UniMin),
        .SecBlink(SecBlink)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] hm(input int hh, input int mm, input int b);
        hm = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 1'(b)};
    endfunction

    function automatic logic [16:0] dut_out();
        dut_out = {DecHor, UniHor, DecMin, UniMin, SecBlink};
    endfunction

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h:%h%h:%h blink=%b expected=%h:%h%h:%h blink=%b",
                     name, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                     exp[16:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // Model: time of day kept as hours/minutes/seconds integers, advanced by whole seconds.
    int m_psc, m_sec, m_hh, m_mm, m_blink, tod;
    bit valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_psc = 0; m_sec = 0; m_hh = 0; m_mm = 0; m_blink = 0;
            valid = 1'b1;
        end else if (valid) begin
            if (SetMode) begin
                m_psc = 0; m_sec = 0; m_blink = 0;
                if (IncMin) m_mm = (m_mm + 1) % 60;
                if (IncHor) m_hh = (m_hh + 1) % 24;
            end else if (m_psc == T - 1) begin
                m_psc   = 0;
                tod     = (m_hh * 3600 + m_mm * 60 + m_sec + 1) % 86400;
                m_hh    = tod / 3600;
                m_mm    = (tod / 60) % 60;
                m_sec   = tod % 60;
                m_blink = 1 - m_blink;
            end else begin
                m_psc++;
            end
        end
    end

    always @(negedge clk) begin
        if (valid) chk("cycle", dut_out(), hm(m_hh, m_mm, m_blink));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_min(input int n);
        IncMin = 1'b1; cyc(n); IncMin = 1'b0;
    endtask

    task automatic hold_hor(input int n);
        IncHor = 1'b1; cyc(n); IncHor = 1'b0;
    endtask

    initial begin
        rst = 1'b1; SetMode = 1'b0; IncHor = 1'b0; IncMin = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("reset_state", dut_out(), hm(0, 0, 0));
        cyc(3);
        chk("before_first_tick", dut_out(), hm(0, 0, 0));
        cyc(1);
        chk("first_tick", dut_out(), hm(0, 0, 1));

        cyc(236);
        chk("minute_carry", dut_out(), hm(0, 1, 0));

        rst = 1'b1; SetMode = 1'b1; cyc(1); rst = 1'b0;
        hold_min(60);
        chk("set_min_wrap60", dut_out(), hm(0, 0, 0));
        hold_hor(24);
        chk("set_hor_wrap24", dut_out(), hm(0, 0, 0));
        IncHor = 1'b1; IncMin = 1'b1; cyc(1); IncHor = 1'b0; IncMin = 1'b0;
        chk("set_both", dut_out(), hm(1, 1, 0));
        hold_hor(22);
        hold_min(58);
        chk("set_2359", dut_out(), hm(23, 59, 0));

        SetMode = 1'b0;
        cyc(239);
        chk("day_before_wrap", dut_out(), hm(23, 59, 1));
        cyc(1);
        chk("day_wrap", dut_out(), hm(0, 0, 0));

        IncMin = 1'b1; IncHor = 1'b1; cyc(1); IncMin = 1'b0; IncHor = 1'b0;
        chk("run_ignore_inc", dut_out(), hm(0, 0, 0));
        cyc(1);
        cyc(1);
        SetMode = 1'b1; cyc(1);
        chk("setmode_on_tc", dut_out(), hm(0, 0, 0));
        hold_min(5);
        chk("set_min5", dut_out(), hm(0, 5, 0));

        SetMode = 1'b0;
        cyc(3);
        chk("resume_before_tick", dut_out(), hm(0, 5, 0));
        cyc(1);
        chk("resume_first_tick", dut_out(), hm(0, 5, 1));
        cyc(236);
        chk("resume_minute", dut_out(), hm(0, 6, 0));

        rst = 1'b1; cyc(1); rst = 1'b0;
        SetMode = 1'b1;
        hold_hor(12);
        hold_min(34);
        SetMode = 1'b0;
        cyc(2);
        chk("at_1234", dut_out(), hm(12, 34, 0));
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid_reset", dut_out(), hm(0, 0, 0));
        cyc(3);
        chk("mid_reset_no_tick", dut_out(), hm(0, 0, 0));
        cyc(1);
        chk("mid_reset_tick", dut_out(), hm(0, 0, 1));

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
